// File: rtl/xbar_timing_tracker.sv
// Frame/slot/header timing tracker: hunts for the frame strobe, verifies alignment,
// then free-runs while flagging strobe violations and counting error cycles.
module xbar_timing_tracker #(
  parameter int MOD         = 80,
  parameter int LOCK_FRAMES = 2,
  parameter int MISS_MAX    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk80,
  input  logic       clk20,
  input  logic       clk10,
  input  logic       load,
  output logic       locked,
  output logic [1:0] slot_idx,
  output logic       hdr_phase,
  output logic       bank,
  output logic       sys_ready,
  output logic       frame_err,
  output logic       slot_err,
  output logic [7:0] err_count
);

  localparam int FW = $clog2(MOD);
  localparam logic [FW-1:0] LAST     = FW'(MOD - 1);
  localparam logic [FW-1:0] SLOT_L   = FW'(MOD / 4);
  localparam logic [FW-1:0] HALF_L   = FW'(MOD / 8);
  localparam logic [FW-1:0] SLOT_END = FW'(MOD / 4 - 1);
  localparam logic [FW-1:0] HALF_END = FW'(MOD / 8 - 1);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  state_t        state;
  logic [FW-1:0] fcnt;
  logic [7:0]    good;
  logic [7:0]    miss;
  logic [1:0]    rcnt;

  logic          at_end;
  logic          frame_bad;
  logic          slot_bad;
  logic [FW-1:0] fcnt_inc;
  logic [FW-1:0] half_num;

  assign at_end    = (fcnt == LAST);
  assign fcnt_inc  = at_end ? '0 : fcnt + FW'(1);
  // A frame strobe is wrong if it is missing at the boundary or present anywhere else.
  assign frame_bad = (clk80 != at_end);
  assign slot_bad  = (clk20 != ((fcnt % SLOT_L) == SLOT_END)) ||
                     (clk10 != ((fcnt % HALF_L) == HALF_END)) ||
                     (load != clk20);

  assign half_num  = fcnt / HALF_L;
  assign slot_idx  = locked ? 2'(fcnt / SLOT_L) : 2'd0;
  assign hdr_phase = locked & half_num[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= HUNT;
      fcnt      <= '0;
      good      <= '0;
      miss      <= '0;
      rcnt      <= '0;
      locked    <= 1'b0;
      bank      <= 1'b1;
      sys_ready <= 1'b0;
      frame_err <= 1'b0;
      slot_err  <= 1'b0;
      err_count <= '0;
    end else begin
      frame_err <= 1'b0;
      slot_err  <= 1'b0;
      case (state)
        HUNT: begin
          fcnt <= '0;
          if (clk80) begin
            state <= VERIFY;
            good  <= '0;
          end
        end
        VERIFY: begin
          if (frame_bad) begin
            state <= HUNT;
            fcnt  <= '0;
          end else begin
            fcnt <= fcnt_inc;
            if (at_end) begin
              // The locking boundary already counts as the first good locked boundary.
              if (good + 8'd1 >= 8'(LOCK_FRAMES)) begin
                state  <= LOCKED;
                locked <= 1'b1;
                miss   <= '0;
                bank   <= ~bank;
                rcnt   <= 2'd1;
              end else begin
                good <= good + 8'd1;
              end
            end
          end
        end
        LOCKED: begin
          fcnt      <= fcnt_inc;
          frame_err <= frame_bad;
          slot_err  <= slot_bad;
          if (frame_bad) begin
            if (miss + 8'd1 >= 8'(MISS_MAX)) begin
              state     <= HUNT;
              locked    <= 1'b0;
              fcnt      <= '0;
              good      <= '0;
              miss      <= '0;
              rcnt      <= '0;
              sys_ready <= 1'b0;
            end else begin
              miss <= miss + 8'd1;
            end
          end else if (at_end) begin
            miss <= '0;
            bank <= ~bank;
            if (rcnt == 2'd2) sys_ready <= 1'b1;
            if (rcnt != 2'd3) rcnt <= rcnt + 2'd1;
          end
          if ((frame_bad || slot_bad) && err_count != 8'hFF)
            err_count <= err_count + 8'd1;
        end
        default: begin
          state  <= HUNT;
          locked <= 1'b0;
          fcnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xbar_timing_tracker.sv
// Directed bench for xbar_timing_tracker: a per-cycle scoreboard of expected outputs
// derived from the intended strobe timeline, plus explicit reset and saturation checks.
module tb_xbar_timing_tracker;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clk80 = 1'b0, clk20 = 1'b0, clk10 = 1'b0, load = 1'b0;
  logic       locked, hdr_phase, bank, sys_ready, frame_err, slot_err;
  logic [1:0] slot_idx;
  logic [7:0] err_count;

  xbar_timing_tracker #(.MOD(80), .LOCK_FRAMES(2), .MISS_MAX(2)) dut (
    .clk(clk), .rst(rst), .clk80(clk80), .clk20(clk20), .clk10(clk10), .load(load),
    .locked(locked), .slot_idx(slot_idx), .hdr_phase(hdr_phase), .bank(bank),
    .sys_ready(sys_ready), .frame_err(frame_err), .slot_err(slot_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       fe, se, lk, bk, rdy, hp;
    logic [1:0] sidx;
    logic [7:0] ec;
  } exp_t;

  exp_t       sbq[$];
  int         checks = 0;
  int         failures = 0;
  int         ph = 0;
  int         rc = 0;
  bit         cur_locked = 0;
  bit         exp_locked = 0;
  logic       exp_bank = 1'b1;
  logic [7:0] exp_ec = 8'd0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of strobes at a falling edge, predict the post-edge outputs,
  // and compare them at the next falling edge.
  task automatic tick(input logic c80, input logic c20, input logic c10, input logic ld);
    exp_t e;
    int   nph;
    clk80 = c80; clk20 = c20; clk10 = c10; load = ld;
    nph  = (ph + 1) % 80;
    e.fe = cur_locked && (c80 != (ph == 79));
    e.se = cur_locked && ((c20 != (ph % 20 == 19)) || (c10 != (ph % 10 == 9)) || (ld != c20));
    if ((e.fe || e.se) && exp_ec != 8'hFF) exp_ec = exp_ec + 8'd1;
    e.ec = exp_ec;
    if (c80 && ph == 79 && exp_locked) begin
      exp_bank = ~exp_bank;
      rc++;
    end
    if (!exp_locked) rc = 0;
    e.lk   = exp_locked;
    e.bk   = exp_bank;
    e.rdy  = exp_locked && (rc >= 3);
    e.sidx = exp_locked ? 2'(nph / 20) : 2'd0;
    e.hp   = exp_locked ? ((nph / 10) % 2 == 1) : 1'b0;
    sbq.push_back(e);
    @(negedge clk);
    e = sbq.pop_front();
    chk($sformatf("frame_err@%0d", ph), {7'd0, frame_err}, {7'd0, e.fe});
    chk($sformatf("slot_err@%0d", ph), {7'd0, slot_err}, {7'd0, e.se});
    chk($sformatf("err_count@%0d", ph), err_count, e.ec);
    chk($sformatf("locked@%0d", ph), {7'd0, locked}, {7'd0, e.lk});
    chk($sformatf("bank@%0d", ph), {7'd0, bank}, {7'd0, e.bk});
    chk($sformatf("sys_ready@%0d", ph), {7'd0, sys_ready}, {7'd0, e.rdy});
    chk($sformatf("slot_idx@%0d", ph), {6'd0, slot_idx}, {6'd0, e.sidx});
    chk($sformatf("hdr_phase@%0d", ph), {7'd0, hdr_phase}, {7'd0, e.hp});
    $display("cyc ph=%0d c80=%0b c20=%0b c10=%0b ld=%0b -> lk=%0b fe=%0b se=%0b ec=%0d bank=%0b rdy=%0b",
             ph, c80, c20, c10, ld, locked, frame_err, slot_err, err_count, bank, sys_ready);
    cur_locked = exp_locked;
    ph = nph;
  endtask

  task automatic ideal();
    tick(ph == 79, ph % 20 == 19, ph % 10 == 9, ph % 20 == 19);
  endtask

  task automatic run_to(input int p);
    while (ph != p) ideal();
  endtask

  // From phase 0 with ideal strobes: HUNT -> VERIFY -> LOCKED on the third boundary.
  task automatic lock_seq();
    repeat (239) ideal();
    exp_locked = 1;
    ideal();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_locked"}, {7'd0, locked}, 8'd0);
    chk({tag, "_bank"}, {7'd0, bank}, 8'd1);
    chk({tag, "_sys_ready"}, {7'd0, sys_ready}, 8'd0);
    chk({tag, "_frame_err"}, {7'd0, frame_err}, 8'd0);
    chk({tag, "_slot_err"}, {7'd0, slot_err}, 8'd0);
    chk({tag, "_err_count"}, err_count, 8'd0);
    chk({tag, "_slot_idx"}, {6'd0, slot_idx}, 8'd0);
    chk({tag, "_hdr_phase"}, {7'd0, hdr_phase}, 8'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");
    rst = 1'b1;

    // Acquisition from reset, then run until sys_ready is expected.
    lock_seq();
    chk("lock_at_240", {7'd0, locked}, 8'd1);
    repeat (160) ideal();
    chk("ready_after_399", {7'd0, sys_ready}, 8'd1);
    chk("no_errors_ideal", err_count, 8'd0);

    // One suppressed frame strobe keeps lock; two consecutive drop it.
    run_to(79);
    tick(1'b0, 1'b1, 1'b1, 1'b1);
    chk("miss1_locked", {7'd0, locked}, 8'd1);
    chk("miss1_count", err_count, 8'd1);
    run_to(79);
    exp_locked = 0;
    tick(1'b0, 1'b1, 1'b1, 1'b1);
    chk("miss2_unlocked", {7'd0, locked}, 8'd0);
    chk("miss2_count", err_count, 8'd2);
    lock_seq();

    // Extra slot strobe mid-slot.
    run_to(10);
    tick(1'b0, 1'b1, 1'b0, 1'b1);
    chk("extra_slot_count", err_count, 8'd3);

    // Missing load, then missing load together with a stray frame strobe.
    run_to(19);
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    run_to(19);
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    chk("both_err_count", err_count, 8'd5);
    chk("stray_keeps_lock", {7'd0, locked}, 8'd1);

    // Header strobe stuck high drives the counter to saturation.
    repeat (300) tick(ph == 79, ph % 20 == 19, 1'b1, ph % 20 == 19);
    chk("err_count_saturated", err_count, 8'hFF);

    // Asynchronous reset in the middle of a locked frame, then reacquire.
    run_to(37);
    rst = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    exp_ec = 8'd0; exp_bank = 1'b1; exp_locked = 0; cur_locked = 0; rc = 0; ph = 0;
    @(negedge clk);
    rst = 1'b1;
    lock_seq();
    chk("relock_bank", {7'd0, bank}, 8'd0);
    repeat (160) ideal();
    chk("relock_ready", {7'd0, sys_ready}, 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
